// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: loads Nk key words on accept, then derives one
// 32-bit schedule word per clock into a word store served through a registered round-key port.
module aes_key_expand #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_vld_i,
  output logic                    key_rdy_o,
  input  logic [1:0]              key_len_i,
  input  logic [MAX_KEY_BITS-1:0] key_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    rk_rd_i,
  input  logic [RK_IDX_W-1:0]     rk_idx_i,
  output logic [127:0]            rk_o,
  output logic                    rk_vld_o
);

  localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int DEPTH  = 4 * (MAX_NR + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam int KW     = MAX_KEY_BITS / 32;

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t              state, state_next;
  logic [31:0]         store [DEPTH];
  logic [AW-1:0]       i_cnt, last_idx, last_in, rk_base;
  logic [3:0]          j_cnt, nk, nk_in;
  logic [RK_IDX_W-1:0] nr, nr_in;
  logic [7:0]          rcon;
  logic                legal, accept, load, last_word, fin, rd_ok;
  logic [31:0]         prev_word, back_word, sub_in, sub_out, temp, new_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    legal   = 1'b0;
    nk_in   = 4'd4;
    nr_in   = RK_IDX_W'(10);
    last_in = AW'(43);
    case (key_len_i)
      2'd0: legal = 1'b1;
      2'd1: begin
        legal   = (MAX_KEY_BITS >= 192);
        nk_in   = 4'd6;
        nr_in   = RK_IDX_W'(12);
        last_in = AW'(51);
      end
      2'd2: begin
        legal   = (MAX_KEY_BITS >= 256);
        nk_in   = 4'd8;
        nr_in   = RK_IDX_W'(14);
        last_in = AW'(59);
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept    = key_vld_i && key_rdy_o;
  assign load      = accept && legal;
  assign last_word = (state == EXPAND) && (i_cnt == last_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (load) state_next = EXPAND;
      EXPAND: if (last_word) state_next = IDLE;
    endcase
  end

  always_comb begin
    key_rdy_o = (state == IDLE);
    busy_o    = (state == EXPAND);
  end

  // One S-box bank serves both the RotWord step (j==0) and the extra 256-bit step (j==4)
  always_comb begin
    prev_word = store[i_cnt - AW'(1)];
    back_word = store[i_cnt - AW'(nk)];
    sub_in    = (j_cnt == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (j_cnt == 4'd0)                    temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j_cnt == 4'd4) temp = sub_out;
    else                                  temp = prev_word;
    new_word = back_word ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      fin      <= 1'b0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      rcon     <= 8'h01;
      nk       <= 4'd4;
      nr       <= RK_IDX_W'(10);
      last_idx <= AW'(43);
    end else begin
      err_o <= accept && !legal;
      fin   <= last_word;
      if (accept)   done_o <= 1'b0;
      else if (fin) done_o <= 1'b1;
      if (load) begin
        nk       <= nk_in;
        nr       <= nr_in;
        last_idx <= last_in;
        i_cnt    <= AW'(nk_in);
        j_cnt    <= '0;
        rcon     <= 8'h01;
      end else if (state == EXPAND) begin
        i_cnt <= i_cnt + AW'(1);
        j_cnt <= (j_cnt == nk - 4'd1) ? 4'd0 : j_cnt + 4'd1;
        if (j_cnt == 4'd0) rcon <= xtime(rcon);
      end
    end
  end

  // Word store is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        for (int k = 0; k < KW; k++)
          if (k < int'(nk_in)) store[AW'(k)] <= key_i[MAX_KEY_BITS-1-32*k -: 32];
      end else if (state == EXPAND) begin
        store[i_cnt] <= new_word;
      end
    end
  end

  assign rk_base = AW'({rk_idx_i, 2'b00});
  assign rd_ok   = rk_rd_i && done_o && (rk_idx_i <= nr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_o     <= '0;
      rk_vld_o <= 1'b0;
    end else if (rk_rd_i) begin
      rk_vld_o <= rd_ok;
      rk_o     <= rd_ok ? {store[rk_base], store[rk_base + AW'(1)],
                           store[rk_base + AW'(2)], store[rk_base + AW'(3)]} : '0;
    end else begin
      rk_vld_o <= 1'b0;
    end
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Parametrised, iterative AES key-schedule engine, successor to the fixed 128-bit, 11-round-key expander. Supports AES-128/192/256, selected per key at runtime. Generates one 32-bit schedule word per clock into an internal word store and serves round keys to the cipher datapath through an indexed, registered read port. Sits between the key-load interface and the round pipeline; the cipher core reads round keys on demand.

Parameters:
MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256); sets key_i width and word-store depth 4*(MAX_NR+1), where MAX_NR = 10/12/14.
RK_IDX_W, 4, width of round-key index.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
key_vld_i  in  1  key offer; accepted when key_vld_i && key_rdy_o
key_rdy_o  out  1  engine can accept a key
key_len_i  in  2  0=128, 1=192, 2=256, 3=illegal; sampled with key
key_i  in  MAX_KEY_BITS  cipher key, left-aligned: key_i[MSB -: 32] = w[0]; unused low bits ignored
busy_o  out  1  expansion in progress
done_o  out  1  schedule complete and valid for current key
err_o  out  1  one-cycle pulse: illegal or unsupported key_len_i accepted
rk_rd_i  in  1  round-key read request
rk_idx_i  in  RK_IDX_W  round index 0..Nr
rk_o  out  128  {w[4i], w[4i+1], w[4i+2], w[4i+3]}
rk_vld_o  out  1  rk_o valid, one cycle after rk_rd_i

Behaviour:
- Nk = 4/6/8 and Nr = 10/12/14 for key_len 0/1/2. Total words T = 4*(Nr+1) = 44/52/60.
- Reset: FSM to IDLE. key_rdy_o=1 (from the first cycle after reset deasserts). busy_o=0, done_o=0, err_o=0, rk_o=0, rk_vld_o=0. Word-store contents are undefined after reset.
- FSM states: IDLE, EXPAND.
- IDLE, on accept:
  - Legal length: write w[0..Nk-1] from key_i in the accept cycle; clear done_o; go to EXPAND next cycle. Set i=Nk, j=0 (i mod Nk), rcon=0x01.
  - Illegal length (3, or larger than MAX_KEY_BITS): pulse err_o next cycle, clear done_o, stay IDLE.
- EXPAND: one word per cycle.
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 -> 0x1B).
  - Else if Nk==8 && j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i++, and j wraps at Nk.
  - After writing w[T-1], return to IDLE and assert done_o on the following cycle.
- Latency: expansion cycles = T-Nk = 40/46/52. done_o rises Nk-independent 1 cycle after the last write, i.e. accept+41/47/53.
- busy_o=1 and key_rdy_o=0 throughout EXPAND. key_vld_i is ignored while busy; a new key is never queued.
- Four S-box lookups are combinational inside the engine. There is no multicycle path; everything completes in a single clock.
- done_o holds until the next key accept or reset. A new accept clears done_o in the same edge it loads w[0].
- Read port:
  - rk_o and rk_vld_o update one cycle after rk_rd_i.
  - rk_vld_o = rk_rd_i && done_o && idx<=Nr, all registered.
  - Invalid read (not done, or idx>Nr): rk_o=0, rk_vld_o=0.
  - With no read, rk_vld_o=0 and rk_o holds its last value.
- Reads during EXPAND return rk_vld_o=0. Reads issued in the same cycle as a new accept see the old done_o=1 and return old-key data.
- Reset mid-expansion: abort immediately; done_o=0, IDLE, key_rdy_o=1.

Test Plan:
- AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, one-cycle vld.
  - done_o at accept+41.
  - Read idx1 -> a0fafe1788542cb123a339392a6c7605, rk_vld_o=1.
  - Read idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - done_o at accept+47.
  - Read idx12 -> e98ba06f448c773c8ecc720401002202.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - done_o at accept+53.
  - Read idx14 -> fe4890d1e6188d0b046df344706c631e.
  - Read idx15 -> rk_vld_o=0, rk_o=0.
- Busy and idle reads:
  - Hold key_vld_i high with a different key during 128 expansion -> key_rdy_o=0, result still matches the first key.
  - rk_rd_i during EXPAND -> rk_vld_o=0.
- Illegal length: key_len_i=3 accepted -> err_o pulses for exactly 1 cycle, busy_o stays 0, done_o=0.
- Reset mid-operation: rst=1 at accept+20 of a 256 expansion -> next cycle busy_o=0, done_o=0, key_rdy_o=1. A following 128 key then expands correctly.
